// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: holds each PC for MEM_LAT cycles, captures the word, hands it to decode.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky fault on misaligned redirects.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic        fault
);

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] pc, pc_n;
  logic        out_valid_n;
  logic        capture;
  logic        redir;
  logic        misaligned;

  function automatic logic [31:0] pc_inc(input logic [31:0] p);
    return p + 32'd4;
  endfunction

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_r;
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault_r <= 1'b0;
    else if (redir && misaligned)
      fault_r <= 1'b1;
  end

  assign fault = fault_r;
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  // A latched fault freezes the sequencer, so redirects are ignored from then on.
  assign redir     = redirect && !fault;
  assign imem_addr = pc;
  assign busy      = (state == FETCH);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pc_n        = pc;
    capture     = 1'b0;
    out_valid_n = out_valid && !out_ready;
    if (redir) begin
      pc_n        = redirect_pc & ~32'h3;
      cnt_n       = 4'd0;
      out_valid_n = 1'b0;
      state_n     = (halt || misaligned) ? HALTED : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (halt) begin
            state_n = HALTED;
            cnt_n   = 4'd0;
          end else if (cnt == LAST) begin
            // Address stays parked on the last count until decode frees the slot.
            if (!out_valid || out_ready) begin
              capture     = 1'b1;
              out_valid_n = 1'b1;
              pc_n        = pc_inc(pc);
              cnt_n       = 4'd0;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        HALTED: begin
          cnt_n = 4'd0;
          if (!halt && !fault)
            state_n = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      cnt       <= 4'd0;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_pc    <= 32'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pc        <= pc_n;
      out_valid <= out_valid_n;
      if (capture) begin
        out_instr <= imem_instr;
        out_pc    <= pc;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: two instances (MEM_LAT=1 and 3) against a transaction-level reference model.
module tb_imem_fetch_ctrl;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_ready;
  logic [31:0] addr  [2];
  logic [31:0] instr [2];
  logic        valid [2];
  logic [31:0] opc   [2];
  logic [31:0] oins  [2];
  logic        busy  [2];
  logic        fault [2];

  int ncmp  = 0;
  int nfail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign instr[0] = mem_word(addr[0]);
  assign instr[1] = mem_word(addr[1]);

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_LAT(1)) u0 (
    .clk(clk), .reset(reset), .imem_addr(addr[0]), .imem_instr(instr[0]),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(valid[0]), .out_ready(out_ready), .out_instr(oins[0]),
    .out_pc(opc[0]), .busy(busy[0]), .fault(fault[0]));

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0100), .MEM_LAT(3)) u1 (
    .clk(clk), .reset(reset), .imem_addr(addr[1]), .imem_instr(instr[1]),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(valid[1]), .out_ready(out_ready), .out_instr(oins[1]),
    .out_pc(opc[1]), .busy(busy[1]), .fault(fault[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, the address being fetched, how many cycles it has
  // already been held, whether fetching is stopped, and the word waiting for decode.
  int          lat      [2] = '{1, 3};
  logic [31:0] boot_pc  [2] = '{32'h0000_0000, 32'h0000_0100};
  logic [31:0] m_pc     [2];
  int          m_held   [2];
  bit          m_stop   [2];
  bit          m_fault  [2];
  bit          m_valid  [2];
  logic [31:0] m_opc    [2];
  logic [31:0] m_oins   [2];

  task automatic mreset(input int d);
    m_pc[d] = boot_pc[d]; m_held[d] = 0; m_stop[d] = 0; m_fault[d] = 0;
    m_valid[d] = 0; m_opc[d] = 0; m_oins[d] = 0;
  endtask

  task automatic mstep(input int d, input bit rd, input logic [31:0] rpc,
                       input bit hl, input bit ry);
    bit slot_free;
    slot_free = !m_valid[d] || ry;
    if (rd && !m_fault[d]) begin
      m_pc[d] = {rpc[31:2], 2'b00};
      m_held[d] = 0;
      m_valid[d] = 0;
      if (ALIGN_EN && rpc[1:0] != 2'b00) begin
        m_fault[d] = 1; m_stop[d] = 1;
      end else begin
        m_stop[d] = hl;
      end
    end else if (!m_stop[d] && !hl && m_held[d] + 1 >= lat[d] && slot_free) begin
      m_opc[d]   = m_pc[d];
      m_oins[d]  = mem_word(m_pc[d]);
      m_valid[d] = 1;
      m_pc[d]    = m_pc[d] + 32'd4;
      m_held[d]  = 0;
    end else begin
      if (m_valid[d] && ry) m_valid[d] = 0;
      if (m_stop[d]) begin
        if (!hl && !m_fault[d]) m_stop[d] = 0;
      end else if (hl) begin
        m_stop[d] = 1; m_held[d] = 0;
      end else if (m_held[d] + 1 < lat[d]) begin
        m_held[d]++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d imem_addr", d), addr[d], m_pc[d]);
      chk($sformatf("u%0d out_valid", d), 32'(valid[d]), 32'(m_valid[d]));
      chk($sformatf("u%0d out_pc", d), opc[d], m_opc[d]);
      chk($sformatf("u%0d out_instr", d), oins[d], m_oins[d]);
      chk($sformatf("u%0d busy", d), 32'(busy[d]), 32'(!m_stop[d]));
      chk($sformatf("u%0d fault", d), 32'(fault[d]), 32'(m_fault[d]));
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s u%0d addr", tag, d), addr[d], boot_pc[d]);
      chk($sformatf("%s u%0d valid", tag, d), 32'(valid[d]), 32'd0);
      chk($sformatf("%s u%0d out_pc", tag, d), opc[d], 32'd0);
      chk($sformatf("%s u%0d out_instr", tag, d), oins[d], 32'd0);
      chk($sformatf("%s u%0d busy", tag, d), 32'(busy[d]), 32'd1);
      chk($sformatf("%s u%0d fault", tag, d), 32'(fault[d]), 32'd0);
    end
  endtask

  task automatic cyc(input bit rd, input logic [31:0] rpc, input bit hl, input bit ry);
    redirect = rd; redirect_pc = rpc; halt = hl; out_ready = ry;
    for (int d = 0; d < 2; d++) mstep(d, rd, rpc, hl, ry);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0; out_ready = 1'b0;
    #2;
    check_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) mreset(d);
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Streaming with decode always ready.
    for (int i = 0; i < 9; i++) cyc(0, 32'd0, 0, 1);

    // Backpressure right after a fresh capture.
    do_reset();
    cyc(0, 32'd0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 32'd0, 0, 0);
    chk("stall out_pc held", opc[0], 32'd0);
    chk("stall addr parked", addr[0], 32'd4);
    cyc(0, 32'd0, 0, 1);
    chk("release next word", opc[0], 32'd4);
    for (int i = 0; i < 3; i++) cyc(0, 32'd0, 0, 0);

    // Redirect flushes a held word.
    cyc(1, 32'h40, 0, 0);
    chk("redirect flush", 32'(valid[0]), 32'd0);
    cyc(0, 32'd0, 0, 1);
    chk("redirect target", opc[0], 32'h40);
    for (int i = 0; i < 6; i++) cyc(0, 32'd0, 0, 1);

    // Halt with a word pending, then resume.
    cyc(0, 32'd0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 32'd0, 1, 1);
    chk("halted busy", 32'(busy[0]), 32'd0);
    for (int i = 0; i < 6; i++) cyc(0, 32'd0, 0, 1);

    // Address wrap at the top of memory.
    cyc(1, 32'hFFFF_FFF8, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 32'd0, 0, 1);

    // Randomized traffic; misaligned targets only occasionally.
    for (int i = 0; i < 400; i++) begin
      bit          rd, hl, ry;
      logic [31:0] rpc;
      rd  = ($urandom_range(0, 19) == 0);
      hl  = ($urandom_range(0, 9) == 0);
      ry  = ($urandom_range(0, 9) < 7);
      rpc = $urandom;
      if (ALIGN_EN || $urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cyc(rd, rpc, hl, ry);
    end

    // Misaligned redirect.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 32'd0, 0, 1);
    cyc(1, 32'h42, 0, 1);
    chk("misaligned fault", 32'(fault[0]), 32'(ALIGN_EN));
    for (int i = 0; i < 5; i++) cyc(0, 32'd0, 0, 1);
    cyc(1, 32'h80, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 32'd0, 0, 1);

    // Asynchronous reset in the middle of a cycle.
    cyc(0, 32'd0, 0, 0);
    reset = 1'b1;
    #2;
    check_reset_state("async");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) mreset(d);
    for (int i = 0; i < 8; i++) cyc(0, 32'd0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
